// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared types and constants for the FP multiplier/divider back end.
// Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    // Width of the signed biased exponent delivered by the upstream datapath
    localparam int EXP_W   = 10;
    // Width of the raw mantissa product/quotient (value = man / 2^46)
    localparam int MAN_W   = 48;
    // Stored fraction width of an IEEE-754 single
    localparam int FRAC_W  = 23;
    // Largest biased exponent value; reaching it means overflow to infinity
    localparam int EXP_MAX = 255;
    // Canonical quiet NaN produced for every NaN result
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Handshake/pipeline sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // IEEE-754 single-precision field layout shared by the FP blocks
    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [FRAC_W-1:0] frac;
    } fp_single_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_rne
// Purpose  : Combinational round-to-nearest-even of a 24-bit significand.
// Revision : 1.0  initial release
// ============================================================================
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W:0]   sig,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac,
    output logic              carry,
    output logic              inexact
);

    logic inc;

    // Round up above the halfway point, or exactly at it when the LSB is odd;
    // carry flags the all-ones significand wrapping into the next binade.
    always_comb begin
        inc     = guard & (sticky | sig[0]);
        frac    = sig[FRAC_W-1:0] + FRAC_W'(inc);
        carry   = inc & (&sig);
        inexact = guard | sticky;
    end

endmodule : fp_round_rne
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_pack
// Purpose  : Normalize, round (RNE), range-check and pack an IEEE-754 single
//            from the sign/exponent/mantissa of the FP mul/div datapath.
//            Fixed 4-state sequence, valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             ovf,
    output logic             unf,
    output logic             inexact
);

    localparam logic signed [EXP_W:0] E_MAX = $signed((EXP_W+1)'(EXP_MAX));

    state_t state;

    // Operand captured in IDLE
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W-1:0] man_q;
    logic             zero_q;
    logic             inf_q;
    logic             nan_q;

    // Normalized operand registered in NORM (leading one sits at bit 46)
    logic [MAN_W-2:0]        man_n;
    logic signed [EXP_W:0]   e_n;
    logic                    sticky_n;

    // Normalization datapath
    logic signed [EXP_W:0]   e_in;
    logic [MAN_W-2:0]        norm_man;
    logic signed [EXP_W:0]   norm_e;
    logic                    norm_sticky;

    // Rounding / packing datapath
    logic                    rnd_sticky;
    logic [FRAC_W-1:0]       rnd_frac;
    logic                    rnd_carry;
    logic                    rnd_inexact;
    logic signed [EXP_W:0]   e_fin;
    fp_single_t              pk;
    logic                    pk_ovf;
    logic                    pk_unf;
    logic                    pk_inexact;

    assign in_ready = (state == S_IDLE);
    assign e_in     = {exp_q[EXP_W-1], exp_q};

    // Bring the leading one to bit 46; a bit lost on the right shift joins sticky
    always_comb begin
        norm_man    = man_q[MAN_W-2:0];
        norm_e      = e_in;
        norm_sticky = 1'b0;
        if (man_q[MAN_W-1]) begin
            norm_man    = man_q[MAN_W-1:1];
            norm_e      = e_in + 11'sd1;
            norm_sticky = man_q[0];
        end else if (man_q[MAN_W-2]) begin
            norm_man    = man_q[MAN_W-2:0];
        end else begin
            norm_man    = {man_q[MAN_W-3:0], 1'b0};
            norm_e      = e_in - 11'sd1;
        end
    end

    assign rnd_sticky = (|man_n[21:0]) | sticky_n;

    fp_round_rne u_round (
        .sig     (man_n[46:23]),
        .guard   (man_n[22]),
        .sticky  (rnd_sticky),
        .frac    (rnd_frac),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    assign e_fin = e_n + $signed({{EXP_W{1'b0}}, rnd_carry});

    // Range check and pack; special-case flags override with priority nan > inf > zero
    always_comb begin
        pk         = '{sign: sign_q, exp: e_fin[7:0], frac: rnd_frac};
        pk_ovf     = 1'b0;
        pk_unf     = 1'b0;
        pk_inexact = rnd_inexact;
        if (nan_q) begin
            pk         = QNAN;
            pk_inexact = 1'b0;
        end else if (inf_q) begin
            pk         = '{sign: sign_q, exp: 8'hFF, frac: '0};
            pk_inexact = 1'b0;
        end else if (zero_q) begin
            pk         = '{sign: sign_q, exp: 8'h00, frac: '0};
            pk_inexact = 1'b0;
        end else if (e_fin >= E_MAX) begin
            pk         = '{sign: sign_q, exp: 8'hFF, frac: '0};
            pk_ovf     = 1'b1;
            pk_inexact = 1'b1;
        end else if (e_fin <= 11'sd0) begin
            pk         = '{sign: sign_q, exp: 8'h00, frac: '0};
            pk_unf     = 1'b1;
            pk_inexact = 1'b1;
        end
    end

    // Sequencer: capture, normalize, round/pack, then hold until downstream accepts
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            man_q     <= '0;
            zero_q    <= 1'b0;
            inf_q     <= 1'b0;
            nan_q     <= 1'b0;
            man_n     <= '0;
            e_n       <= '0;
            sticky_n  <= 1'b0;
            out_valid <= 1'b0;
            result    <= 32'h0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= in_exp;
                        man_q  <= in_man;
                        zero_q <= in_zero;
                        inf_q  <= in_inf;
                        nan_q  <= in_nan;
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    man_n    <= norm_man;
                    e_n      <= norm_e;
                    sticky_n <= norm_sticky;
                    state    <= S_RND;
                end
                S_RND: begin
                    result    <= pk;
                    ovf       <= pk_ovf;
                    unf       <= pk_unf;
                    inexact   <= pk_inexact;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule : fp_normalize_pack
`default_nettype wire
